default_hash_core: RTL and testbench

- Pipelined multiply-shift address hash. Maps a 64-bit address to a bucket index in [0, num_buckets).
- Sits between the address-mapping front end and the bucket tables.
- Bucket count and hash coefficients are runtime-configurable.
- Diagnostic outputs expose the intermediate values: sva, upper, lower, lg_num_buckets, coe_a and coe_b.

---
 rtl/default_hash_core.sv | 136 +++++++++++++
 tb/tb_default_hash_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/default_hash_core.sv
// default_hash_core: two-stage multiply-shift address hash.
// Maps an address to a bucket index in [0, 2^lg_num_buckets) using
// h = coe_a*sva + coe_b (mod 2^64), then keeping the top lg bits of h.
// Bucket count and coefficients are runtime loadable. Each request captures
// the configuration at stage 1 and carries it, so later writes never alter
// results that are already in flight.
module default_hash_core #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SVA_SHIFT  = 0,
  parameter logic [63:0] COE_A_INIT = 64'h9E3779B97F4A7C15,
  parameter logic [63:0] COE_B_INIT = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_nb_we,
  input  logic [31:0]           cfg_num_buckets,
  input  logic                  cfg_coe_we,
  input  logic [63:0]           cfg_coe_a,
  input  logic [63:0]           cfg_coe_b,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_hash,
  output logic [ADDR_WIDTH-1:0] dbg_sva,
  output logic [31:0]           dbg_upper,
  output logic [31:0]           dbg_lower,
  output logic [6:0]            lg_num_buckets,
  output logic [63:0]           coe_a,
  output logic [63:0]           coe_b
);

  // Live configuration
  logic [6:0]            lg_q;
  logic [63:0]           coe_a_q;
  logic [63:0]           coe_b_q;
  logic [6:0]            nb_lg;

  // Stage 1 registers
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_sva;
  logic [63:0]           s1_pp_lo;
  logic [31:0]           s1_pp_hi;
  logic [63:0]           s1_coe_b;
  logic [6:0]            s1_lg;

  // Stage 1 combinational inputs
  logic [ADDR_WIDTH-1:0] sva_d;
  logic [63:0]           pp_lo_d;
  logic [31:0]           pp_hi_d;

  // Stage 2 combinational result
  logic [63:0]           sum_d;
  logic [6:0]            shamt_d;
  logic [ADDR_WIDTH-1:0] hash_d;

  // floor(log2(cfg_num_buckets)): index of the highest set bit, 0 for 0 or 1
  always_comb begin
    nb_lg = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (cfg_num_buckets[i]) nb_lg = 7'(i);
    end
  end

  // Configuration registers; both loads may occur in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lg_q    <= '0;
      coe_a_q <= COE_A_INIT | 64'd1;
      coe_b_q <= COE_B_INIT;
    end else begin
      if (cfg_nb_we) lg_q <= nb_lg;
      if (cfg_coe_we) begin
        coe_a_q <= cfg_coe_a | 64'd1;
        coe_b_q <= cfg_coe_b;
      end
    end
  end

  // Stage 1 operands: two 32x64 partial products of the split address.
  // Only the low 32 bits of coe_a*upper survive the <<32, so a 32x32 product
  // suffices for the high partial.
  always_comb begin
    sva_d   = req_addr >> SVA_SHIFT;
    pp_lo_d = coe_a_q * {32'h0, sva_d[31:0]};
    pp_hi_d = coe_a_q[31:0] * sva_d[63:32];
  end

  // Stage 1 register: sva, partial products and config snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sva   <= '0;
      s1_pp_lo <= '0;
      s1_pp_hi <= '0;
      s1_coe_b <= '0;
      s1_lg    <= '0;
    end else begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_sva   <= sva_d;
        s1_pp_lo <= pp_lo_d;
        s1_pp_hi <= pp_hi_d;
        s1_coe_b <= coe_b_q;
        s1_lg    <= lg_q;
      end
    end
  end

  // Stage 2 arithmetic: sum partials, add coe_b, keep the top lg bits.
  // lg=0 is special-cased so the shifter never sees a 64-bit shift.
  always_comb begin
    sum_d   = s1_pp_lo + {s1_pp_hi, 32'h0} + s1_coe_b;
    shamt_d = 7'd64 - s1_lg;
    hash_d  = '0;
    if (s1_lg != 7'd0) hash_d = sum_d >> shamt_d;
  end

  // Stage 2 register: result and its valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hash  <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) rsp_hash <= hash_d;
    end
  end

  assign dbg_sva        = s1_sva;
  assign dbg_upper      = s1_sva[63:32];
  assign dbg_lower      = s1_sva[31:0];
  assign lg_num_buckets = lg_q;
  assign coe_a          = coe_a_q;
  assign coe_b          = coe_b_q;

endmodule

// File: tb/tb_default_hash_core.sv
// Self-checking bench for default_hash_core: directed cases plus a randomized
// request/config stream compared against an arithmetic reference model.
module tb_default_hash_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_nb_we;
  logic [31:0] cfg_num_buckets;
  logic        cfg_coe_we;
  logic [63:0] cfg_coe_a;
  logic [63:0] cfg_coe_b;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_hash;
  logic [63:0] dbg_sva;
  logic [31:0] dbg_upper;
  logic [31:0] dbg_lower;
  logic [6:0]  lg_num_buckets;
  logic [63:0] coe_a;
  logic [63:0] coe_b;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  default_hash_core #(
    .ADDR_WIDTH(64),
    .SVA_SHIFT(0),
    .COE_A_INIT(64'h9E3779B97F4A7C15),
    .COE_B_INIT(64'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_nb_we(cfg_nb_we),
    .cfg_num_buckets(cfg_num_buckets),
    .cfg_coe_we(cfg_coe_we),
    .cfg_coe_a(cfg_coe_a),
    .cfg_coe_b(cfg_coe_b),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_hash(rsp_hash),
    .dbg_sva(dbg_sva),
    .dbg_upper(dbg_upper),
    .dbg_lower(dbg_lower),
    .lg_num_buckets(lg_num_buckets),
    .coe_a(coe_a),
    .coe_b(coe_b)
  );

  always #5 clk = ~clk;

  // Reference: floor(log2(n)), 0 for n of 0 or 1
  function automatic logic [6:0] ref_lg(input logic [31:0] n);
    logic [6:0] r = 0;
    while (n > 1) begin
      n = n / 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Reference: top lg bits of (a*addr + b) mod 2^64
  function automatic logic [63:0] ref_hash(input logic [63:0] addr, input logic [63:0] a,
                                           input logic [63:0] b, input logic [6:0] lg);
    logic [63:0] h;
    h = a * addr + b;
    if (lg == 0) return 64'd0;
    return h / (64'd1 << (64 - lg));
  endfunction

  // Advance past the next rising edge; inputs driven/outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nb(input logic [31:0] n);
    cfg_nb_we = 1'b1;
    cfg_num_buckets = n;
    tick();
    cfg_nb_we = 1'b0;
  endtask

  task automatic set_coe(input logic [63:0] a, input logic [63:0] b);
    cfg_coe_we = 1'b1;
    cfg_coe_a = a;
    cfg_coe_b = b;
    tick();
    cfg_coe_we = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its response.
  // lat counts rising edges from the cycle the request is driven.
  task automatic issue(input logic [63:0] addr, output logic got, output logic [63:0] hash,
                       output int lat, output logic [63:0] sva, output logic [31:0] up,
                       output logic [31:0] lo);
    got = 1'b0; hash = '0; lat = -1; sva = '0; up = '0; lo = '0;
    req_valid = 1'b1;
    req_addr = addr;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        req_valid = 1'b0;
        sva = dbg_sva; up = dbg_upper; lo = dbg_lower;
      end
      if (rsp_valid) begin
        got = 1'b1; hash = rsp_hash; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_nb_we = 0; cfg_num_buckets = 0; cfg_coe_we = 0; cfg_coe_a = 0; cfg_coe_b = 0;
    req_valid = 0; req_addr = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total_cnt++; if (lg_num_buckets !== 7'd0) $display("FAIL reset_lg got %0d want 0", lg_num_buckets); else pass_cnt++;
    total_cnt++; if (coe_a !== 64'h9E3779B97F4A7C15) $display("FAIL reset_coe_a got %h want 9e3779b97f4a7c15", coe_a); else pass_cnt++;
    total_cnt++; if (coe_b !== 64'h0) $display("FAIL reset_coe_b got %h want 0", coe_b); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_hash !== 64'h0) $display("FAIL reset_rsp_hash got %h want 0", rsp_hash); else pass_cnt++;
    total_cnt++; if (dbg_sva !== 64'h0 || dbg_upper !== 32'h0 || dbg_lower !== 32'h0)
      $display("FAIL reset_dbg got %h/%h/%h want 0", dbg_sva, dbg_upper, dbg_lower); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [31:0] nbs [3] = '{32'd4, 32'd8, 32'd16};
    logic [6:0]  lgs [3] = '{7'd2, 7'd3, 7'd4};
    logic [63:0] hs  [3] = '{64'd2, 64'd5, 64'd10};
    logic got; logic [63:0] h, sva; int lat; logic [31:0] up, lo;
    set_coe(64'd1, 64'd0);
    for (int i = 0; i < 3; i++) begin
      set_nb(nbs[i]);
      total_cnt++; if (lg_num_buckets !== lgs[i]) $display("FAIL dir_lg[%0d] got %0d want %0d", i, lg_num_buckets, lgs[i]); else pass_cnt++;
      issue(64'hAAAAAAAABBBBBBBB, got, h, lat, sva, up, lo);
      total_cnt++; if (!got || lat != 2) $display("FAIL dir_latency[%0d] got valid=%b lat=%0d want 1/2", i, got, lat); else pass_cnt++;
      total_cnt++; if (h !== hs[i]) $display("FAIL dir_hash[%0d] got %0d want %0d", i, h, hs[i]); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (up !== 32'hAAAAAAAA || lo !== 32'hBBBBBBBB || sva !== 64'hAAAAAAAABBBBBBBB)
          $display("FAIL dir_dbg got %h/%h/%h want aaaaaaaabbbbbbbb/aaaaaaaa/bbbbbbbb", sva, up, lo); else pass_cnt++;
      end
    end
  endtask

  task automatic test_coe_b();
    logic got; logic [63:0] h, sva; int lat; logic [31:0] up, lo;
    set_coe(64'd1, 64'h4000000000000000);
    set_nb(32'd4);
    issue(64'hAAAAAAAABBBBBBBB, got, h, lat, sva, up, lo);
    total_cnt++; if (!got || h !== 64'd3) $display("FAIL coe_b_add got valid=%b hash=%0d want 1/3", got, h); else pass_cnt++;
    set_coe(64'd1, 64'h6000000000000000);
    set_nb(32'd16);
    issue(64'hAAAAAAAABBBBBBBB, got, h, lat, sva, up, lo);
    total_cnt++; if (!got || h !== 64'd0) $display("FAIL coe_b_wrap got valid=%b hash=%0d want 1/0", got, h); else pass_cnt++;
    set_coe(64'd0, 64'd0);
    total_cnt++; if (coe_a !== 64'd1) $display("FAIL coe_a_odd got %h want 1", coe_a); else pass_cnt++;
    total_cnt++; if (coe_b !== 64'd0) $display("FAIL coe_b_load got %h want 0", coe_b); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [31:0] nbs [3] = '{32'd0, 32'd1, 32'd12};
    logic [6:0]  lgs [3] = '{7'd0, 7'd0, 7'd3};
    logic got; logic [63:0] h, sva, a; int lat; logic [31:0] up, lo;
    for (int i = 0; i < 3; i++) begin
      set_nb(nbs[i]);
      total_cnt++; if (lg_num_buckets !== lgs[i]) $display("FAIL bnd_lg[%0d] got %0d want %0d", i, lg_num_buckets, lgs[i]); else pass_cnt++;
    end
    set_nb(32'hFFFFFFFF);
    total_cnt++; if (lg_num_buckets !== 7'd31) $display("FAIL bnd_lg_max got %0d want 31", lg_num_buckets); else pass_cnt++;
    set_coe({$urandom, $urandom}, {$urandom, $urandom});
    set_nb(32'd1);
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      issue(a, got, h, lat, sva, up, lo);
      total_cnt++; if (!got || h !== 64'd0) $display("FAIL bnd_lg0_hash[%0d] got valid=%b hash=%h want 1/0", i, got, h); else pass_cnt++;
    end
  endtask

  // Back-to-back random requests with interleaved config writes; each result
  // must use the config in force in the cycle its request was driven.
  task automatic test_back_to_back();
    localparam int N = 80;
    logic        exp_v [N+2];
    logic [63:0] exp_h [N+2];
    logic [63:0] m_a, m_b, a, b, addr;
    logic [6:0]  m_lg;
    logic [31:0] nb;
    logic r, nw, cw;
    m_a = coe_a; m_b = coe_b; m_lg = lg_num_buckets;
    for (int k = 0; k < N + 2; k++) begin
      r  = (k < N) && ($urandom_range(0, 4) != 0);
      nw = ($urandom_range(0, 3) == 0);
      cw = ($urandom_range(0, 5) == 0);
      addr = {$urandom, $urandom};
      nb = $urandom >> $urandom_range(0, 31);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      req_valid = r; req_addr = addr;
      cfg_nb_we = nw; cfg_num_buckets = nb;
      cfg_coe_we = cw; cfg_coe_a = a; cfg_coe_b = b;
      exp_v[k] = r;
      exp_h[k] = ref_hash(addr, m_a, m_b, m_lg);
      if (nw) m_lg = ref_lg(nb);
      if (cw) begin m_a = a | 64'd1; m_b = b; end
      tick();
      if (k >= 1) begin
        total_cnt++; if (rsp_valid !== exp_v[k-1])
          $display("FAIL b2b_valid[%0d] got %b want %b", k - 1, rsp_valid, exp_v[k-1]); else pass_cnt++;
        if (exp_v[k-1]) begin
          total_cnt++; if (rsp_hash !== exp_h[k-1])
            $display("FAIL b2b_hash[%0d] got %h want %h", k - 1, rsp_hash, exp_h[k-1]); else pass_cnt++;
        end
      end
    end
    req_valid = 0; cfg_nb_we = 0; cfg_coe_we = 0;
    total_cnt++; if (lg_num_buckets !== m_lg) $display("FAIL b2b_final_lg got %0d want %0d", lg_num_buckets, m_lg); else pass_cnt++;
    total_cnt++; if (coe_a !== m_a) $display("FAIL b2b_final_coe_a got %h want %h", coe_a, m_a); else pass_cnt++;
  endtask

  task automatic test_reset_in_flight();
    set_coe(64'd3, 64'd5);
    set_nb(32'd256);
    req_valid = 1'b1; req_addr = {$urandom, $urandom};
    tick();
    req_addr = {$urandom, $urandom};
    tick();
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rif_pre_valid got %b want 1", rsp_valid); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0 || rsp_hash !== 64'd0)
      $display("FAIL rif_async got valid=%b hash=%h want 0/0", rsp_valid, rsp_hash); else pass_cnt++;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rif_stale[%0d] got %b want 0", i, rsp_valid); else pass_cnt++;
    end
    total_cnt++; if (lg_num_buckets !== 7'd0 || coe_a !== 64'h9E3779B97F4A7C15 || coe_b !== 64'd0)
      $display("FAIL rif_cfg got %0d/%h/%h want 0/9e3779b97f4a7c15/0", lg_num_buckets, coe_a, coe_b); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_coe_b();
    test_boundaries();
    test_back_to_back();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
